// File: rtl/uart_tx_engine_if.sv
// ---------------------------------------------------------------------------
// uart_tx_engine_if
//   Groups the character/format/handshake signals of the UART transmitter.
//   The master drives the request side (frame format, character, request,
//   break). The slave (the transmitter) drives the serial line and ready.
//
//   Signals:
//     tx            serial line (slave -> master)
//     ready         1 = transmitter idle, request will be accepted
//     dataBits      data bit count = dataBits + 5
//     hasParity     1 = append parity bit
//     parityMode    00 even, 01 odd, 10 mark, 11 space
//     extraStopBit  1 = two stop bits
//     clockDivisor  clk cycles per bit (0 behaves as 1)
//     data          character, bits at or above the width are ignored
//     transmitReq   request strobe, honoured only while ready=1
//     sendBreak     level, requests a line break
// ---------------------------------------------------------------------------
interface uart_tx_engine_if #(
  parameter int DIV_W = 24
);
  logic             tx;
  logic             ready;
  logic [1:0]       dataBits;
  logic             hasParity;
  logic [1:0]       parityMode;
  logic             extraStopBit;
  logic [DIV_W-1:0] clockDivisor;
  logic [7:0]       data;
  logic             transmitReq;
  logic             sendBreak;

  modport master (
    output dataBits, hasParity, parityMode, extraStopBit, clockDivisor,
    output data, transmitReq, sendBreak,
    input  tx, ready
  );

  modport slave (
    input  dataBits, hasParity, parityMode, extraStopBit, clockDivisor,
    input  data, transmitReq, sendBreak,
    output tx, ready
  );
endinterface

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//   Serial UART transmitter. One 5..8 bit character is accepted per
//   transmitReq/ready handshake and sent as start bit, data bits (LSB first),
//   optional parity bit and one or two stop bits. A held sendBreak level
//   drives the line low, followed by two bit times of mark once released.
//   Frame format and baud divisor are captured when a frame (or break) starts,
//   so later input changes never disturb the waveform in flight.
//
//   Ports:
//     clk   single clock, everything on its rising edge
//     rst   synchronous, active-high reset; aborts any frame at once
//     bus   uart_tx_engine_if.slave (format inputs, data, handshake, tx)
// ---------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DIV_W   = 24,
  parameter bit IDLE_TX = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  uart_tx_engine_if.slave      bus
);

  localparam logic MARK  = IDLE_TX;
  localparam logic SPACE = ~IDLE_TX;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t           state_reg;
  logic             tx_reg;
  logic             ready_reg;
  logic [DIV_W-1:0] reload_reg;    // cycles per bit minus one
  logic [DIV_W-1:0] cnt_reg;       // counts down to 0 within one bit
  logic [7:0]       shift_reg;     // data bits still to send, bit 0 on the line next
  logic [2:0]       idx_reg;       // index of the data bit on the line
  logic [2:0]       last_idx_reg;  // index of the final data bit
  logic             has_par_reg;
  logic             par_bit_reg;
  logic             extra_stop_reg;
  logic             stop_left_reg; // one more bit time to go (2nd stop / 2nd mark-after-break bit)
  logic             mab_reg;       // BREAK is in its mark-after-break tail

  // Combinational helpers computed from the live inputs; only used on the
  // cycle a frame or break is accepted.
  logic [DIV_W-1:0] div_reload;
  logic [1:0]       mask_shift;
  logic [7:0]       data_mask;
  logic             par_even;
  logic             par_bit;
  logic             bit_done;

  always_comb begin
    div_reload = (bus.clockDivisor == '0) ? '0 : bus.clockDivisor - DIV_W'(1);
    mask_shift = 2'd3 - bus.dataBits;
    data_mask  = 8'hFF >> mask_shift;
    par_even   = ^(bus.data & data_mask);
    par_bit    = par_even;
    case (bus.parityMode)
      2'b00:   par_bit = par_even;
      2'b01:   par_bit = ~par_even;
      2'b10:   par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
    bit_done = (cnt_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tx_reg         <= MARK;
      ready_reg      <= 1'b1;
      reload_reg     <= '0;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      idx_reg        <= '0;
      last_idx_reg   <= '0;
      has_par_reg    <= 1'b0;
      par_bit_reg    <= 1'b0;
      extra_stop_reg <= 1'b0;
      stop_left_reg  <= 1'b0;
      mab_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg    <= MARK;
          ready_reg <= 1'b1;
          // Break has priority over a simultaneous request.
          if (bus.sendBreak) begin
            state_reg  <= BREAK;
            tx_reg     <= SPACE;
            ready_reg  <= 1'b0;
            reload_reg <= div_reload;
            mab_reg    <= 1'b0;
          end else if (bus.transmitReq) begin
            state_reg      <= START;
            tx_reg         <= SPACE;
            ready_reg      <= 1'b0;
            reload_reg     <= div_reload;
            cnt_reg        <= div_reload;
            shift_reg      <= bus.data & data_mask;
            idx_reg        <= '0;
            last_idx_reg   <= {1'b0, bus.dataBits} + 3'd4;
            has_par_reg    <= bus.hasParity;
            par_bit_reg    <= par_bit;
            extra_stop_reg <= bus.extraStopBit;
          end
        end

        START: begin
          if (!bit_done) begin
            cnt_reg <= cnt_reg - DIV_W'(1);
          end else begin
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
            cnt_reg   <= reload_reg;
          end
        end

        DATA: begin
          if (!bit_done) begin
            cnt_reg <= cnt_reg - DIV_W'(1);
          end else begin
            cnt_reg <= reload_reg;
            if (idx_reg == last_idx_reg) begin
              if (has_par_reg) begin
                state_reg <= PARITY;
                tx_reg    <= par_bit_reg;
              end else begin
                state_reg     <= STOP;
                tx_reg        <= MARK;
                stop_left_reg <= extra_stop_reg;
              end
            end else begin
              // Shift so the next bit sits at position 0.
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
              idx_reg   <= idx_reg + 3'd1;
            end
          end
        end

        PARITY: begin
          if (!bit_done) begin
            cnt_reg <= cnt_reg - DIV_W'(1);
          end else begin
            state_reg     <= STOP;
            tx_reg        <= MARK;
            cnt_reg       <= reload_reg;
            stop_left_reg <= extra_stop_reg;
          end
        end

        STOP: begin
          tx_reg <= MARK;
          if (!bit_done) begin
            cnt_reg <= cnt_reg - DIV_W'(1);
          end else if (stop_left_reg) begin
            stop_left_reg <= 1'b0;
            cnt_reg       <= reload_reg;
          end else begin
            // A pending break is taken from IDLE on the next cycle, so the
            // stop bit always completes first.
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end

        BREAK: begin
          ready_reg <= 1'b0;
          if (!mab_reg) begin
            tx_reg <= SPACE;
            if (!bus.sendBreak) begin
              // Release: two bit times of mark using the divisor latched at entry.
              mab_reg       <= 1'b1;
              tx_reg        <= MARK;
              cnt_reg       <= reload_reg;
              stop_left_reg <= 1'b1;
            end
          end else begin
            tx_reg <= MARK;
            if (!bit_done) begin
              cnt_reg <= cnt_reg - DIV_W'(1);
            end else if (stop_left_reg) begin
              stop_left_reg <= 1'b0;
              cnt_reg       <= reload_reg;
            end else begin
              state_reg <= IDLE;
              ready_reg <= 1'b1;
              mab_reg   <= 1'b0;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= MARK;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx    = tx_reg;
  assign bus.ready = ready_reg;

endmodule
